enc_scan: RTL and testbench

Sequential 8-to-3 scanning encoder: the inverse of the team's 3-to-8 decoder. It accepts an 8-bit multi-hot vector over a valid/ready handshake and emits the 3-bit index of every set bit, one per output handshake, in priority order. It flags the final beat, and reports an all-zero vector as a single empty beat. It sits between request-vector producers and any consumer that needs binary indices, for example to drive the 3-to-8 decoder back.

---
 rtl/enc_pkg.sv | 14 +
 rtl/enc_scan_pri_enc.sv | 39 +++
 rtl/enc_scan.sv | 95 +++++++++
 tb/tb_enc_scan.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the enc_scan scanning encoder.
//   state_t : scan controller states (IDLE waits for a vector, EMIT streams indices)
//   W, CW   : default input vector width and code width
package enc_pkg;

  localparam int W  = 8;
  localparam int CW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/enc_scan_pri_enc.sv
// pri_enc: combinational priority encoder over a W-bit mask.
// Macro: MSB_FIRST_EN selects highest-bit-first priority; when undefined,
// bit 0 has the highest priority.
// Ports:
//   mask        in  W   bits still to be reported
//   idx         out CW  index of the highest-priority set bit (0 when mask is 0)
//   any         out 1   at least one bit of mask is set
//   one_or_less out 1   mask has zero or one bit set
module pri_enc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  output logic [CW-1:0] idx,
  output logic          any,
  output logic          one_or_less
);

  // Scan so that the winning bit is the last one assigned: ascending scan
  // leaves the highest set bit, descending scan leaves the lowest.
  always_comb begin
    idx = '0;
`ifdef MSB_FIRST_EN
    for (int i = 0; i < W; i++) begin
      if (mask[i]) idx = CW'(i);
    end
`else
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = CW'(i);
    end
`endif
  end

  assign any = |mask;

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  assign one_or_less = ((mask & (mask - W'(1))) == '0);

endmodule

// File: rtl/enc_scan.sv
// enc_scan: sequential 8-to-3 scanning encoder. Captures a multi-hot vector
// over a valid/ready handshake and emits the index of every set bit, one per
// output handshake, in priority order. An all-zero vector yields one beat
// flagged empty.
// Macro: MSB_FIRST_EN (highest set bit first; default lowest set bit first).
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   asynchronous active-high reset
//   in_valid  in  1   D is valid
//   in_ready  out 1   block can accept a vector (IDLE only)
//   D         in  W   multi-hot request vector
//   out_valid out 1   code/last/empty valid
//   out_ready in  1   consumer takes the current beat
//   code      out CW  index of the current set bit
//   last      out 1   final beat for this vector
//   empty     out 1   captured vector was all-zero
module enc_scan #(
  parameter int W  = enc_pkg::W,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] code,
  output logic          last,
  output logic          empty
);

  import enc_pkg::*;

  state_t        state, state_next;
  logic [W-1:0]  mask, mask_next;
  logic [CW-1:0] idx;
  logic          any;
  logic          one_or_less;

  pri_enc #(.W(W), .CW(CW)) u_pri_enc (
    .mask        (mask),
    .idx         (idx),
    .any         (any),
    .one_or_less (one_or_less)
  );

  // State and remaining-bit mask; reset throws away any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
    end
  end

  // Capture in IDLE; in EMIT retire one bit per taken beat, and return to
  // IDLE once the beat holding the final (or only) bit is taken.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mask_next  = D;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (one_or_less) begin
            mask_next  = '0;
            state_next = IDLE;
          end else begin
            mask_next[idx] = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        mask_next  = '0;
      end
    endcase
  end

  // in_ready is held low while reset is asserted even though state is IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT);
  assign code      = out_valid ? idx : '0;
  assign last      = out_valid & one_or_less;
  assign empty     = out_valid & ~any;

endmodule

// File: tb/tb_enc_scan.sv
// tb_enc_scan: self-checking bench for enc_scan. Expected beats come from a
// reference model that lists set-bit positions in priority order.
// Macro: MSB_FIRST_EN (must match the RTL build).
module tb_enc_scan;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] D;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] code;
  logic       last;
  logic       empty;

  int vectors    = 0;
  int miscompares = 0;

  enc_scan dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .last      (last),
    .empty     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: number of beats and the code of beat n.
  function automatic int count_ones(input logic [7:0] v);
    int c = 0;
    for (int k = 0; k < 8; k++) c += int'(v[k]);
    return c;
  endfunction

  function automatic int num_beats(input logic [7:0] v);
    return (count_ones(v) == 0) ? 1 : count_ones(v);
  endfunction

  function automatic int nth_code(input logic [7:0] v, input int n);
    int seen = 0;
    int pos;
    for (int k = 0; k < 8; k++) begin
`ifdef MSB_FIRST_EN
      pos = 7 - k;
`else
      pos = k;
`endif
      if (v[pos]) begin
        if (seen == n) return pos;
        seen++;
      end
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    step(); step();
    vectors++;
    if ({in_ready, out_valid, code, last, empty} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got rdy=%b v=%b code=%0d last=%b empty=%b, want all 0",
               in_ready, out_valid, code, last, empty);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] v = 8'b0000_0100;
    D = v; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || code !== 3'd2 || last !== 1'b1 || empty !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_beat: got v=%b code=%0d last=%b empty=%b rdy=%b, want v=1 code=2 last=1 empty=0 rdy=0",
               out_valid, code, last, empty, in_ready);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_ready_return: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_multi();
    logic [7:0] v = 8'b1010_0010;
    int nb = num_beats(v);
    D = v; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < nb; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || int'(code) != nth_code(v, j) || last !== (j == nb - 1) || empty !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL multi_beat%0d: got v=%b code=%0d last=%b empty=%b, want v=1 code=%0d last=%b empty=0",
                 j, out_valid, code, last, empty, nth_code(v, j), (j == nb - 1));
      end
      step();
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL multi_end: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero();
    D = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || code !== 3'd0 || last !== 1'b1 || empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL zero_beat: got v=%b code=%0d last=%b empty=%b, want v=1 code=0 last=1 empty=1",
               out_valid, code, last, empty);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_end: got rdy=%b v=%b empty=%b, want rdy=1 v=0 empty=0", in_ready, out_valid, empty);
    end
  endtask

  // All-ones vector with out_ready pattern 1,0,0 repeating and stray in_valid pulses.
  task automatic test_stall();
    logic [7:0] v = 8'hFF;
    int beat = 0;
    int cyc  = 0;
    D = v; in_valid = 1'b1; out_ready = 1'b0;
    step();
    while (beat < 8 && cyc < 40) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = 1'($urandom_range(0, 1));
      D         = 8'($urandom);
      vectors++;
      if (out_valid !== 1'b1 || int'(code) != nth_code(v, beat) || last !== (beat == 7) ||
          empty !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_beat%0d cyc%0d: got v=%b code=%0d last=%b empty=%b rdy=%b, want v=1 code=%0d last=%b empty=0 rdy=0",
                 beat, cyc, out_valid, code, last, empty, in_ready, nth_code(v, beat), (beat == 7));
      end
      if (out_ready) beat++;
      cyc++;
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (beat != 8 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_end: got beats=%0d v=%b rdy=%b, want beats=8 v=0 rdy=1", beat, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    D = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    step();
    D = 8'h80;
    vectors++;
    if (out_valid !== 1'b1 || code !== 3'd0 || last !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got v=%b code=%0d last=%b, want v=1 code=0 last=1", out_valid, code, last);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || code !== 3'd7 || last !== 1'b1 || empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got v=%b code=%0d last=%b empty=%b, want v=1 code=7 last=1 empty=0",
               out_valid, code, last, empty);
    end
    step();
  endtask

  task automatic test_reset_mid_emit();
    D = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, code, last, empty, in_ready} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got v=%b code=%0d last=%b empty=%b rdy=%b, want all 0",
               out_valid, code, last, empty, in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    D = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || code !== 3'd4 || last !== 1'b1 || empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_recover: got v=%b code=%0d last=%b empty=%b, want v=1 code=4 last=1 empty=0",
               out_valid, code, last, empty);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      int nb;
      int beat = 0;
      int cyc  = 0;
      v  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      nb = num_beats(v);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_ready: got rdy=%b, want 1", n, in_ready);
      end
      D = v; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      while (beat < nb && cyc < 60) begin
        out_ready = ($urandom_range(0, 3) != 0);
        vectors++;
        if (out_valid !== 1'b1 || int'(code) != nth_code(v, beat) || last !== (beat == nb - 1) ||
            empty !== (count_ones(v) == 0)) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_beat%0d D=%h: got v=%b code=%0d last=%b empty=%b, want v=1 code=%0d last=%b empty=%b",
                   n, beat, v, out_valid, code, last, empty, nth_code(v, beat), (beat == nb - 1),
                   (count_ones(v) == 0));
        end
        if (out_ready) beat++;
        cyc++;
        step();
      end
      out_ready = 1'b0;
      vectors++;
      if (beat != nb || out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_end: got beats=%0d v=%b, want beats=%0d v=0", n, beat, out_valid, nb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
